// File: rtl/mem_ctrl.sv
// mem_ctrl: programmable-latency word RAM controller serving the data cache (single words and
// 4-word wrapped line fills) and the bypass master. Define MEM_CTRL_WBUF_EN for a posted write buffer.
module mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int AW      = 12,
  parameter int DEPTH   = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_burst,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  output logic [31:0]   c_rdata,
  output logic          c_valid,
  output logic          c_done,
  input  logic          ba_req,
  input  logic          ba_we,
  input  logic [AW-1:0] ba_addr,
  input  logic [31:0]   ba_wdata,
  output logic [31:0]   ba_rdata,
  output logic          ba_done,
  output logic          busy
);

  localparam int         WW       = AW - 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [1:0]    beat_q;
  logic          sel_ba_q;
  logic          we_q;
  logic          burst_q;
  logic          pri_ba_q;
  logic [WW-1:0] word_q;
  logic [31:0]   c_rdata_q;
  logic [31:0]   ba_rdata_q;
  logic          c_valid_q;
  logic          c_done_q;
  logic          ba_done_q;

  logic [31:0]   mem [DEPTH];

  logic          grant_ba;
  logic          grant_en;
  logic          req_we;
  logic [WW-1:0] req_word;
  logic [31:0]   req_wdata;
  logic [1:0]    beat_idx;
  logic [WW-1:0] rd_word;
  logic [31:0]   rd_data;
  logic          posted;
  logic          mem_we;
  logic [WW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          unused_addr_lsbs;

  // Round robin: with both masters requesting, the one not granted last time wins.
  always_comb begin
    grant_ba  = ba_req & (~c_req | pri_ba_q);
    req_we    = grant_ba ? ba_we : c_we;
    req_word  = grant_ba ? ba_addr[AW-1:2] : c_addr[AW-1:2];
    req_wdata = grant_ba ? ba_wdata : c_wdata;
    // Critical word first; the 2-bit sum wraps inside the aligned 16-byte line.
    beat_idx  = word_q[1:0] + beat_q;
    rd_word   = {word_q[WW-1:2], beat_idx};
  end

  assign rd_data          = mem[rd_word];
  assign unused_addr_lsbs = ^{c_addr[1:0], ba_addr[1:0]};

`ifdef MEM_CTRL_WBUF_EN
  logic          wb_valid_q;
  logic [3:0]    wb_cnt_q;
  logic [WW-1:0] wb_addr_q;
  logic [31:0]   wb_data_q;
  logic          posted_q;
  logic          wb_drain;

  assign wb_drain  = wb_valid_q && (wb_cnt_q == 4'd0);
  // A drain and a new grant may share an edge, so later reads always see the drained word.
  assign grant_en  = ~wb_valid_q | wb_drain;
  assign posted    = posted_q;
  assign mem_we    = wb_drain;
  assign mem_waddr = wb_addr_q;
  assign mem_wdata = wb_data_q;
  assign busy      = (state_q != IDLE) | wb_valid_q;
`else
  logic [31:0]   wdata_q;

  assign grant_en  = 1'b1;
  assign posted    = 1'b0;
  assign mem_we    = (state_q == WAIT) && (cnt_q == 4'd0) && we_q;
  assign mem_waddr = word_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
`endif

  // NOTE: the RAM array has no reset; its contents must survive a controller reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      beat_q     <= 2'd0;
      sel_ba_q   <= 1'b0;
      we_q       <= 1'b0;
      burst_q    <= 1'b0;
      pri_ba_q   <= 1'b0;
      word_q     <= '0;
      c_rdata_q  <= 32'd0;
      ba_rdata_q <= 32'd0;
      c_valid_q  <= 1'b0;
      c_done_q   <= 1'b0;
      ba_done_q  <= 1'b0;
`ifdef MEM_CTRL_WBUF_EN
      wb_valid_q <= 1'b0;
      wb_cnt_q   <= 4'd0;
      wb_addr_q  <= '0;
      wb_data_q  <= 32'd0;
      posted_q   <= 1'b0;
`else
      wdata_q    <= 32'd0;
`endif
    end else begin
`ifdef MEM_CTRL_WBUF_EN
      if (wb_drain)        wb_valid_q <= 1'b0;
      else if (wb_valid_q) wb_cnt_q   <= wb_cnt_q - 4'd1;
`endif
      unique case (state_q)
        IDLE: begin
          if ((c_req || ba_req) && grant_en) begin
            sel_ba_q <= grant_ba;
            pri_ba_q <= ~grant_ba;
            we_q     <= req_we;
            burst_q  <= ~grant_ba & ~c_we & c_burst;
            word_q   <= req_word;
            cnt_q    <= CNT_INIT;
            beat_q   <= 2'd0;
            state_q  <= WAIT;
`ifdef MEM_CTRL_WBUF_EN
            posted_q <= req_we;
            if (req_we) begin
              wb_valid_q <= 1'b1;
              wb_cnt_q   <= CNT_INIT;
              wb_addr_q  <= req_word;
              wb_data_q  <= req_wdata;
            end
`else
            wdata_q  <= req_wdata;
`endif
          end
        end
        WAIT: begin
          if (posted) begin
            if (sel_ba_q) ba_done_q <= 1'b1;
            else          c_done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (we_q) begin
            if (sel_ba_q) ba_done_q <= 1'b1;
            else          c_done_q  <= 1'b1;
            state_q <= DONE;
          end else if (burst_q) begin
            c_rdata_q <= rd_data;
            c_valid_q <= 1'b1;
            beat_q    <= 2'd1;
            state_q   <= BEAT;
          end else if (sel_ba_q) begin
            ba_rdata_q <= rd_data;
            ba_done_q  <= 1'b1;
            state_q    <= DONE;
          end else begin
            c_rdata_q <= rd_data;
            c_valid_q <= 1'b1;
            c_done_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        BEAT: begin
          c_rdata_q <= rd_data;
          beat_q    <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            c_done_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          c_valid_q <= 1'b0;
          c_done_q  <= 1'b0;
          ba_done_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_rdata  = c_rdata_q;
  assign c_valid  = c_valid_q;
  assign c_done   = c_done_q;
  assign ba_rdata = ba_rdata_q;
  assign ba_done  = ba_done_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Main-memory controller between the data cache and the backing word RAM. Serves cache single-word writes and 4-word line fills, plus single-word accesses from the bypass (BA) master, with a fixed programmable access latency. Arbitrates the two masters round-robin and returns data through a per-beat valid/done handshake. Replaces the zero-latency combinational memory behind the cache.

## Interface
- LATENCY, 4, cycles from request acceptance to first data/write completion; legal 1..15
- AW, 12, byte address width; word address is addr[AW-1:2]
- DEPTH, 1024, RAM words (2^(AW-2))
- rstn: asynchronous, active-high; clock clk.
- clk  in  1  clock
- rstn  in  1  asynchronous, active-high reset
- c_req  in  1  cache request; held until c_done
- c_we  in  1  1 = write one word, 0 = read
- c_burst  in  1  read only: 4-word line fill; ignored when c_we=1
- c_addr  in  12  byte address
- c_wdata  in  32  write data
- c_rdata  out  32  read data, valid when c_valid
- c_valid  out  1  one read beat present
- c_done  out  1  request complete (one-cycle pulse)
- ba_req, ba_we, ba_addr[11:0], ba_wdata[31:0]  in  bypass master, same rules as cache, no burst
- ba_rdata  out  32  read data, valid when ba_done
- ba_done  out  1  completion pulse
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, WAIT, BEAT, DONE. Reset values: state IDLE, all outputs 0, cnt 0, rr pointer = cache.
- IDLE: on edge with any req high, grant one master, latch we/burst/addr/wdata, cnt <= LATENCY-1, go WAIT.
- Arbitration: only one requesting -> it wins. Both -> master not granted last time wins; rr pointer updates on every grant.
- WAIT: cnt decrements each edge. Edge with cnt==0 performs the access: write -> RAM[word]<=wdata, go DONE; single read -> rdata latched, go DONE; burst -> beat 0 latched, go BEAT.
- Burst order: critical word first, wrapping within the aligned 16-byte line: indices w, w+1, w+2, w+3 mod 4 on addr[3:2]; addr[11:4] fixed. Word index must not carry into addr[4].
- BEAT: c_valid=1, c_rdata=current beat; each edge loads next beat; after beat 2 is presented, edge loads beat 3 and goes DONE.
- DONE: lasts exactly one cycle. Granted master's done=1; for reads valid/rdata also presented (cache: c_valid=1 on final/only beat; writes: c_valid=0). All requests ignored in DONE; next edge -> IDLE.
- Requester drops req during the DONE cycle; a req still high in IDLE afterwards is a new request.
- Latched request fields are used; master changes to addr/wdata after acceptance have no effect.
- Reset mid-operation: state returns to IDLE immediately, outputs 0; RAM contents are not reset; a write not yet performed is discarded.

## Timing
- Request sampled at edge N: single access done high in cycle after edge N+LATENCY (LATENCY+1 cycles req-to-done inclusive of accept).
- Burst: c_valid high cycles after edges N+LATENCY .. N+LATENCY+3; c_done with the fourth beat only.
- Back-to-back: minimum spacing acceptance-to-acceptance = LATENCY+2 cycles (single), LATENCY+5 (burst).
- LATENCY=1: WAIT lasts one cycle.
- Outputs are all registered; no combinational path from req to any output.

## Configuration
- MEM_CTRL_WBUF_EN defined: one-entry posted write buffer. Write accepted in IDLE when buffer empty -> DONE next edge (done 2 cycles after accept edge), buffer drains to RAM LATENCY cycles after accept in background. While buffer full: further writes and all reads stay pending in IDLE (not granted) until drain completes; drain completion and a new grant may occur on the same edge. busy includes buffer-full. Reset empties buffer without writing.
- Not defined: writes use WAIT path like reads; no buffer logic present.

## Test plan
- LATENCY=4: cache write 0x0A4 <- 0xDEADBEEF, then single read 0x0A4 -> c_done and c_rdata=0xDEADBEEF 5 cycles after each accept.
- RAM words 0x0C0..0x0CC = 0x10..0x13; burst read at 0x0C8 -> beats 0x12,0x13,0x10,0x11 on 4 consecutive cycles, c_done only with 0x11.
- c_req and ba_req rise same edge twice in a row -> first grant cache (reset pointer), second grant BA; each done pulses once, never both.
- Hold req high through DONE -> exactly one done per request, re-accepted on the IDLE edge after DONE.
- Assert rstn during burst beat 1 -> all outputs 0 same cycle, state IDLE; subsequent read of 0x0C0 returns 0x10.
- MEM_CTRL_WBUF_EN: write 0x010 <- 0x55 then immediate read 0x010 -> write done after 2 cycles, read granted only after drain, returns 0x55.
